// File: rtl/regfile_sb.sv
// 2-read/1-write register file with a per-register busy scoreboard.
// Register 0 and addresses >= REGNUM read as zero and never go busy.
module regfile_sb #(
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 3,
  parameter int REGNUM = 8,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [RWIDTH-1:0] wa3,
  input  logic [DWIDTH-1:0] wd3,
  input  logic [RWIDTH-1:0] ra1,
  input  logic [RWIDTH-1:0] ra2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  input  logic              rsv,
  input  logic [RWIDTH-1:0] rsva,
  output logic              busy1,
  output logic              busy2
);

  // Only registers 1..REGNUM-1 hold storage; register 0 is implicit.
  logic [DWIDTH-1:0] rf_q [1:REGNUM-1];
  logic [DWIDTH-1:0] rf_d [1:REGNUM-1];
  logic [REGNUM-1:1] busy_q;
  logic [REGNUM-1:1] busy_d;

  // Reserve wins over write on busy because it belongs to the newer instruction.
  always_comb begin
    for (int i = 1; i < REGNUM; i++) begin
      if (we3 && (wa3 == i[RWIDTH-1:0])) begin
        rf_d[i] = wd3;
      end else begin
        rf_d[i] = rf_q[i];
      end

      if (rsv && (rsva == i[RWIDTH-1:0])) begin
        busy_d[i] = 1'b1;
      end else if (we3 && (wa3 == i[RWIDTH-1:0])) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < REGNUM; i++) begin
        rf_q[i] <= {DWIDTH{1'b0}};
      end
      busy_q <= {(REGNUM-1){1'b0}};
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  // Returns {busy, data}; unmatched addresses (0 or out of range) fall through to zero.
  function automatic logic [DWIDTH:0] read_port(input logic [RWIDTH-1:0] ra);
    logic [DWIDTH:0] r;
    r = {(DWIDTH+1){1'b0}};
    for (int i = 1; i < REGNUM; i++) begin
      if (ra == i[RWIDTH-1:0]) begin
        if ((BYPASS != 0) && we3 && (wa3 == ra)) begin
          r = {1'b0, wd3};
        end else begin
          r = {busy_q[i], rf_q[i]};
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    {busy1, rd1} = read_port(ra1);
    {busy2, rd2} = read_port(ra2);
  end

endmodule
